serv_bus_loader: RTL and testbench

Host-side bus initiator that turns a byte-stream command protocol (e.g. from a UART receiver) into single-word transactions on the SERV-style data bus (adr/dat/sel/we/cyc → rdt/ack). It shares the memory responder with the SERV core's dbus through an external arbiter. It loads program images into system memory, reads them back, and holds the SERV core in reset until released.

---
 rtl/serv_bus_loader_pkg.sv | 24 ++
 rtl/serv_bus_loader_tx.sv | 64 ++++++
 rtl/serv_bus_loader.sv | 162 ++++++++++++++++
 tb/tb_serv_bus_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_bus_loader_pkg.sv
// Shared definitions for the SERV bus loader: command opcodes, response
// status bytes and the command FSM state encoding.
package serv_bus_loader_pkg;

  // Command opcodes (ASCII)
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_GO    = 8'h47;  // 'G'
  localparam logic [7:0] OP_HALT  = 8'h48;  // 'H'

  // Response status bytes
  localparam logic [7:0] STS_OK      = 8'h06;
  localparam logic [7:0] STS_TIMEOUT = 8'h15;
  localparam logic [7:0] STS_BADCMD  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

endpackage

// File: rtl/serv_bus_loader_tx.sv
// Response serializer for the bus loader.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_load                 capture i_resp/i_len and start sending
//   i_resp[39:0]           response bytes, byte 0 in [7:0] is sent first
//   i_len[2:0]             number of bytes to send (1 or 5)
//   o_tx_data/o_tx_valid   byte stream towards the sink
//   i_tx_ready             sink accepts the presented byte
//   o_done                 final byte is being accepted this cycle
module serv_bus_loader_tx (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [39:0] i_resp,
  input  logic [2:0]  i_len,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done
);

  // Bytes 1..4 wait here; byte 0 goes straight to o_tx_data on load.
  logic [31:0] rest_q;
  logic [2:0]  idx;
  logic [2:0]  len_q;
  logic        fire;
  logic        last;

  assign fire   = o_tx_valid && i_tx_ready;
  assign last   = (idx == len_q - 3'd1);
  assign o_done = fire && last;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
      idx        <= 3'd0;
      len_q      <= 3'd0;
    end else if (i_load) begin
      o_tx_valid <= 1'b1;
      o_tx_data  <= i_resp[7:0];
      idx        <= 3'd0;
      len_q      <= i_len;
    end else if (fire) begin
      if (last) begin
        o_tx_valid <= 1'b0;
        o_tx_data  <= 8'h00;
        idx        <= 3'd0;
      end else begin
        o_tx_data <= rest_q[7:0];
        idx       <= idx + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      rest_q <= i_resp[39:8];
    end else if (fire) begin
      rest_q <= {8'h00, rest_q[31:8]};
    end
  end

endmodule

// File: rtl/serv_bus_loader.sv
// Host-side bus initiator: decodes a byte-stream command protocol into
// single-word SERV-style bus transactions and controls the CPU reset.
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_rx_data/i_rx_valid/o_rx_ready   command byte stream in
//   o_tx_data/o_tx_valid/i_tx_ready   response byte stream out
//   o_bus_adr/dat/sel/we/cyc          bus request (word aligned)
//   i_bus_rdt/i_bus_ack               bus response
//   o_cpu_reset                       holds the SERV core in reset while high
module serv_bus_loader
  import serv_bus_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_bus_adr,
  output logic [31:0] o_bus_dat,
  output logic [3:0]  o_bus_sel,
  output logic        o_bus_we,
  output logic        o_bus_cyc,
  input  logic [31:0] i_bus_rdt,
  input  logic        i_bus_ack,
  output logic        o_cpu_reset
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_t           state, state_n;
  logic [1:0]       byte_cnt;
  logic             is_write;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rx_fire;
  logic             byte_last;
  logic             tx_load;
  logic             tx_done;
  logic [39:0]      resp_bytes;
  logic [2:0]       resp_len;

  assign rx_fire   = i_rx_valid && o_rx_ready;
  assign byte_last = (byte_cnt == 2'd3);

  always_comb begin
    state_n    = state;
    tx_load    = 1'b0;
    resp_bytes = 40'h0;
    resp_len   = 3'd1;
    case (state)
      S_IDLE: begin
        if (rx_fire) begin
          if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) begin
            state_n = S_ADDR;
          end else begin
            state_n          = S_RESP;
            tx_load          = 1'b1;
            resp_bytes[7:0]  = (i_rx_data == OP_GO || i_rx_data == OP_HALT) ? STS_OK : STS_BADCMD;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire && byte_last) state_n = is_write ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_fire && byte_last) state_n = S_BUS;
      end
      S_BUS: begin
        // Ack only counts while the request is actually up.
        if (o_bus_cyc && i_bus_ack) begin
          state_n    = S_RESP;
          tx_load    = 1'b1;
          resp_bytes = {i_bus_rdt, STS_OK};
          resp_len   = is_write ? 3'd1 : 3'd5;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n         = S_RESP;
          tx_load         = 1'b1;
          resp_bytes[7:0] = STS_TIMEOUT;
        end
      end
      S_RESP: begin
        if (tx_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      byte_cnt    <= 2'd0;
      is_write    <= 1'b0;
      tmo_cnt     <= '0;
      o_rx_ready  <= 1'b0;
      o_bus_cyc   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_sel   <= 4'h0;
      o_bus_adr   <= 32'h0;
      o_bus_dat   <= 32'h0;
      o_cpu_reset <= 1'b1;
    end else begin
      state      <= state_n;
      // Registered so it is low in reset and tracks the state being entered.
      o_rx_ready <= (state_n == S_IDLE) || (state_n == S_ADDR) || (state_n == S_DATA);

      if (rx_fire) begin
        case (state)
          S_IDLE: begin
            byte_cnt <= 2'd0;
            is_write <= (i_rx_data == OP_WRITE);
            if (i_rx_data == OP_GO)   o_cpu_reset <= 1'b0;
            if (i_rx_data == OP_HALT) o_cpu_reset <= 1'b1;
          end
          S_ADDR: begin
            // Shift LSB-first bytes down from the top. Bits [9:8] are dropped on
            // each shift; on the final shift those are byte 0's low bits, which
            // leaves the address word aligned.
            o_bus_adr <= {i_rx_data, o_bus_adr[31:10], 2'b00};
            byte_cnt  <= byte_cnt + 2'd1;
          end
          S_DATA: begin
            o_bus_dat <= {i_rx_data, o_bus_dat[31:8]};
            byte_cnt  <= byte_cnt + 2'd1;
          end
          default: ;
        endcase
      end

      if (state != S_BUS && state_n == S_BUS) begin
        o_bus_cyc <= 1'b1;
        o_bus_we  <= is_write;
        o_bus_sel <= 4'hF;
        tmo_cnt   <= '0;
      end else if (state == S_BUS && state_n != S_BUS) begin
        o_bus_cyc <= 1'b0;
        o_bus_we  <= 1'b0;
        o_bus_sel <= 4'h0;
      end else if (state == S_BUS) begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end
    end
  end

  serv_bus_loader_tx u_tx (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tx_load),
    .i_resp     (resp_bytes),
    .i_len      (resp_len),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_done     (tx_done)
  );

endmodule

// File: tb/tb_serv_bus_loader.sv
module tb_serv_bus_loader;

  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_bus_adr;
  logic [31:0] o_bus_dat;
  logic [3:0]  o_bus_sel;
  logic        o_bus_we;
  logic        o_bus_cyc;
  logic [31:0] bus_rdt;
  logic        bus_ack;
  logic        o_cpu_reset;

  serv_bus_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_bus_adr   (o_bus_adr),
    .o_bus_dat   (o_bus_dat),
    .o_bus_sel   (o_bus_sel),
    .o_bus_we    (o_bus_we),
    .o_bus_cyc   (o_bus_cyc),
    .i_bus_rdt   (bus_rdt),
    .i_bus_ack   (bus_ack),
    .o_cpu_reset (o_cpu_reset)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- responder: mapped region 0x01xxxxxx, registered ack ----
  logic [31:0] resp_mem [logic [21:0]];
  logic [21:0] rkey;
  assign rkey = o_bus_adr[23:2];

  initial begin
    bus_ack = 1'b0;
    bus_rdt = 32'h0;
  end

  always @(posedge i_clk) begin
    if (o_bus_cyc && o_bus_adr[31:24] == 8'h01) begin
      bus_ack <= 1'b1;
      bus_rdt <= resp_mem.exists(rkey) ? resp_mem[rkey] : 32'h0;
      if (o_bus_we) resp_mem[rkey] = o_bus_dat;
    end else begin
      bus_ack <= 1'b0;
    end
  end

  // ---------------- reference model and expectation queues ----------------
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          dur;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] model_mem [logic [21:0]];
  logic        model_cpu_reset;
  logic        mon_hold;
  logic        hold_ready;

  // ---------------- tx_ready driver: random backpressure -------------------
  initial begin
    i_tx_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- response monitor ---------------------------------------
  logic       tx_stalled = 1'b0;
  logic [7:0] tx_last = 8'h00;

  always @(negedge i_clk) begin
    if (mon_hold) begin
      tx_stalled = 1'b0;
    end else begin
      if (tx_stalled) begin
        chk("tx_hold_valid", o_tx_valid, 1'b1);
        chk("tx_hold_data", o_tx_data, tx_last);
      end
      if (o_tx_valid) chk("rx_ready_in_resp", o_rx_ready, 1'b0);
      if (o_bus_cyc)  chk("rx_ready_in_bus", o_rx_ready, 1'b0);
      if (o_tx_valid && i_tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got byte %0h with nothing expected", o_tx_data);
        end else begin
          chk("tx_byte", o_tx_data, exp_q.pop_front());
        end
      end
      tx_stalled = o_tx_valid && !i_tx_ready;
      tx_last    = o_tx_data;
    end
  end

  // ---------------- bus monitor ---------------------------------------------
  logic        prev_cyc = 1'b0;
  int          cyc_len = 0;
  logic [31:0] start_adr = 32'h0;

  always @(negedge i_clk) begin
    if (mon_hold) begin
      prev_cyc = 1'b0;
      cyc_len  = 0;
    end else begin
      if (o_bus_cyc) begin
        if (!prev_cyc) begin
          start_adr = o_bus_adr;
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: cyc raised at adr %0h with nothing expected", o_bus_adr);
          end else begin
            chk("bus_adr", o_bus_adr, bus_q[0].adr);
            chk("bus_we", o_bus_we, bus_q[0].we);
            chk("bus_sel", o_bus_sel, 4'hF);
            if (bus_q[0].we) chk("bus_dat", o_bus_dat, bus_q[0].dat);
          end
        end else begin
          chk("bus_adr_stable", o_bus_adr, start_adr);
        end
        cyc_len++;
      end else if (prev_cyc) begin
        if (bus_q.size() != 0) begin
          chk("bus_cyc_len", cyc_len, bus_q[0].dur);
          void'(bus_q.pop_front());
        end
        chk("bus_we_low", o_bus_we, 1'b0);
        cyc_len = 0;
      end
      prev_cyc = o_bus_cyc;
    end
  end

  // ---------------- stimulus tasks (called at a negedge) -------------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready) begin
      @(negedge i_clk);
      n++;
      if (n > 5000) begin
        $display("FAIL rx_ready_wait: o_rx_ready stuck at %0b, required 1", o_rx_ready);
        $fatal(1);
      end
    end
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [31:0] a, input logic [31:0] d, input bit is_w);
    logic [31:0] wa;
    logic [31:0] rd;
    bus_exp_t    e;
    bit          mapped;
    wa     = {a[31:2], 2'b00};
    mapped = (a[31:24] == 8'h01);
    e.adr  = wa;
    e.we   = is_w;
    e.dat  = d;
    e.dur  = mapped ? 2 : TMO;
    bus_q.push_back(e);
    if (!mapped) begin
      exp_q.push_back(8'h15);
    end else if (is_w) begin
      exp_q.push_back(8'h06);
      model_mem[wa[23:2]] = d;
    end else begin
      rd = model_mem.exists(wa[23:2]) ? model_mem[wa[23:2]] : 32'h0;
      exp_q.push_back(8'h06);
      for (int i = 0; i < 4; i++) exp_q.push_back(rd[8*i +: 8]);
    end
    send_byte(is_w ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (is_w) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic do_simple(input logic [7:0] b);
    if (b == 8'h47) begin
      exp_q.push_back(8'h06);
      model_cpu_reset = 1'b0;
    end else if (b == 8'h48) begin
      exp_q.push_back(8'h06);
      model_cpu_reset = 1'b1;
    end else begin
      exp_q.push_back(8'h3F);
    end
    send_byte(b);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0 || o_tx_valid) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_pending", exp_q.size() + bus_q.size(), 0);
    exp_q.delete();
    bus_q.delete();
    chk("cpu_reset", o_cpu_reset, model_cpu_reset);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence -------------------------------------------
  logic [31:0] ra;
  logic [31:0] rdat;
  logic [7:0]  rb;
  logic [7:0]  d0;
  int          kind;
  int          n;

  initial begin
    i_reset         = 1'b1;
    i_rx_valid      = 1'b0;
    i_rx_data       = 8'h00;
    mon_hold        = 1'b1;
    hold_ready      = 1'b0;
    model_cpu_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_cpu_reset", o_cpu_reset, 1'b1);
    chk("rst_cyc", o_bus_cyc, 1'b0);
    chk("rst_we", o_bus_we, 1'b0);
    chk("rst_sel", o_bus_sel, 4'h0);
    chk("rst_adr", o_bus_adr, 32'h0);
    chk("rst_dat", o_bus_dat, 32'h0);
    chk("rst_tx_valid", o_tx_valid, 1'b0);
    chk("rst_tx_data", o_tx_data, 8'h00);
    chk("rst_rx_ready", o_rx_ready, 1'b0);
    i_reset  = 1'b0;
    mon_hold = 1'b0;
    @(negedge i_clk);

    // Write then read back a mapped word
    do_cmd(32'h01000010, 32'hDEADBEEF, 1'b1);
    drain();
    chk("mem_word4", resp_mem.exists(22'd4) ? resp_mem[22'd4] : 32'h0, 32'hDEADBEEF);
    do_cmd(32'h01000010, 32'h0, 1'b0);
    drain();

    // Unmapped read times out
    do_cmd(32'h03000000, 32'h0, 1'b0);
    drain();
    chk("idle_after_timeout", o_rx_ready, 1'b1);

    // Bad command, go, halt
    do_simple(8'h00);
    drain();
    do_simple(8'h47);
    drain();
    do_simple(8'h48);
    drain();

    // Response held by the sink for 10 cycles
    hold_ready = 1'b1;
    do_cmd(32'h01000010, 32'h0, 1'b0);
    n = 0;
    while (!o_tx_valid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("hold_tx_valid", o_tx_valid, 1'b1);
    d0 = o_tx_data;
    chk("hold_first_byte", d0, 8'h06);
    repeat (10) begin
      @(negedge i_clk);
      chk("hold_data", o_tx_data, d0);
      chk("hold_rx_ready", o_rx_ready, 1'b0);
    end
    hold_ready = 1'b0;
    drain();

    // Reset in the middle of a bus transaction
    do_simple(8'h47);
    drain();
    mon_hold = 1'b1;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    n = 0;
    while (!o_bus_cyc && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("rstmid_cyc_up", o_bus_cyc, 1'b1);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("rstmid_cyc", o_bus_cyc, 1'b0);
    chk("rstmid_we", o_bus_we, 1'b0);
    chk("rstmid_sel", o_bus_sel, 4'h0);
    chk("rstmid_cpu_reset", o_cpu_reset, 1'b1);
    i_reset         = 1'b0;
    model_cpu_reset = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      chk("rstmid_no_tx", o_tx_valid, 1'b0);
    end
    mon_hold = 1'b0;
    do_cmd(32'h01000020, 32'h12345678, 1'b1);
    drain();
    chk("mem_word8", resp_mem.exists(22'd8) ? resp_mem[22'd8] : 32'h0, 32'h12345678);

    // Randomized command mix
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      ra   = 32'h01000000 | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      rdat = $urandom;
      if (kind <= 2) begin
        do_cmd(ra, rdat, 1'b1);
      end else if (kind <= 5) begin
        do_cmd(ra, 32'h0, 1'b0);
      end else if (kind == 6) begin
        ra[31:24] = 8'($urandom_range(2, 255));
        do_cmd(ra, rdat, ($urandom_range(0, 1) == 1));
      end else if (kind == 7) begin
        do_simple(8'h47);
      end else if (kind == 8) begin
        do_simple(8'h48);
      end else begin
        rb = 8'($urandom_range(0, 255));
        while (rb == 8'h57 || rb == 8'h52 || rb == 8'h47 || rb == 8'h48) rb = 8'($urandom_range(0, 255));
        do_simple(rb);
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
